// File: rtl/sub_bytes_engine.sv
// AES SubBytes / InvSubBytes engine: substitutes a 128-bit state LANES bytes per cycle
// through constant S-box ROMs, with a valid/ready handshake on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The producer holds valid (and its data) until that edge. The consumer may change
// ready freely. in_ready is 1 only in IDLE. out_valid, once set, stays 1 with
// out_state stable until the edge where out_ready is also 1.
module sub_bytes_engine #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   o_dbg_state
);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int GROUPS = 16 / LANES;
  localparam int LG     = $clog2(LANES);

  // Entry 0 is the leftmost byte, so SBOX[x] is the FIPS-197 substitute of x.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [127:0]   r_work;
  logic           r_dec;
  logic [3:0]     r_cnt;
  logic           r_out_valid;
  logic           r_busy;

  logic           w_accept;
  logic           w_last;
  logic [3:0]     w_base;
  logic [7:0]     w_sub     [LANES];
  logic [3:0]     w_sub_idx [LANES];

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == 4'(GROUPS - 1));
  assign w_base   = 4'(r_cnt << LG);

  // One forward (and optionally one inverse) ROM per lane; lane l handles byte cnt*LANES+l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0] w_idx;
    logic [7:0] w_in;
    logic [7:0] w_fwd;
    logic [7:0] w_inv;

    assign w_idx = w_base + 4'(l);
    assign w_in  = r_work[{w_idx, 3'b000} +: 8];
    assign w_fwd = SBOX[w_in];

    if (INV_EN != 0) begin : g_inv
      assign w_inv = INV_SBOX[w_in];
    end else begin : g_no_inv
      assign w_inv = w_fwd;
    end

    assign w_sub[l]     = r_dec ? w_inv : w_fwd;
    assign w_sub_idx[l] = w_idx;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready    = (r_state == S_IDLE);
    o_dbg_state = r_state;
  end

  // Datapath; out_valid and busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work      <= '0;
      r_dec       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_work <= in_state;
        r_dec  <= (INV_EN != 0) && dec;
        r_cnt  <= '0;
      end else if (r_state == S_BUSY) begin
        for (int l = 0; l < LANES; l++) begin
          r_work[{w_sub_idx[l], 3'b000} +: 8] <= w_sub[l];
        end
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_state = r_work;
  assign busy      = r_busy;

endmodule
